// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x5 active-low key matrix, debounces whole scans and
// emits one registered strobe per accepted press (digits 0-9, eight operators).
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [4:0] col_in,
    output logic [3:0] row_out,
    output logic [9:0] Input,
    output logic       plus,
    output logic       minus,
    output logic       mul,
    output logic       div,
    output logic       square,
    output logic       equal,
    output logic       ce,
    output logic       ac,
    output logic [4:0] key_code,
    output logic       key_valid
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;
    logic [4:0]    col_m, col_s;
    logic [DW-1:0] div_cnt;
    logic [1:0]    row;
    logic [19:0]   raw, raw_d;
    logic          sample, scan_end;
    logic [4:0]    ones, cand;
    logic          cand_ok;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [4:0]    code, code_n;
    logic          fire;
    logic [17:0]   strobe, strobe_d;

    assign sample   = div_cnt == DW'(SCAN_DIV - 1);
    assign scan_end = sample && row == 2'd3;
    assign cnt_inc  = cnt + 1'b1;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            col_m   <= '1;
            col_s   <= '1;
            div_cnt <= '0;
            row     <= '0;
            row_out <= 4'b1110;
            raw     <= '0;
        end else begin
            col_m   <= col_in;
            col_s   <= col_m;
            div_cnt <= sample ? '0 : div_cnt + 1'b1;
            raw     <= raw_d;
            if (sample) begin
                row     <= row + 2'd1;
                row_out <= ~(4'b0001 << (row + 2'd1));
            end
        end
    end

    // The candidate is taken from the vector including the row-3 sample of this very cycle.
    always_comb begin
        raw_d = raw;
        if (sample) raw_d[5*int'(row) +: 5] = ~col_s;
        ones = '0;
        cand = '0;
        for (int i = 0; i < 20; i++) begin
            if (raw_d[i]) begin
                ones = ones + 5'd1;
                cand = 5'(i);
            end
        end
        cand_ok = ones == 5'd1 && cand <= 5'd17;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            code      <= '0;
            strobe    <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            code      <= code_n;
            strobe    <= strobe_d;
            key_valid <= fire;
            if (fire) key_code <= code;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code;
        fire    = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: if (cand_ok) begin
                    state_n = DEBOUNCE;
                    cnt_n   = CW'(1);
                    code_n  = cand;
                end
                DEBOUNCE: if (!cand_ok) state_n = IDLE;
                    else if (cand != code) begin
                        cnt_n  = CW'(1);
                        code_n = cand;
                    end else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) begin
                            state_n = HELD;
                            fire    = 1'b1;
                        end
                    end
                HELD: if (!cand_ok) begin
                    state_n = RELEASE;
                    cnt_n   = CW'(1);
                end
                RELEASE: if (cand_ok) state_n = HELD;
                    else begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE_SCANS)) state_n = IDLE;
                    end
                default: state_n = IDLE;
            endcase
        end
    end

    assign strobe_d = fire ? 18'(1) << code : '0;
    assign Input    = strobe[9:0];
    assign plus     = strobe[10];
    assign minus    = strobe[11];
    assign mul      = strobe[12];
    assign div      = strobe[13];
    assign square   = strobe[14];
    assign equal    = strobe[15];
    assign ce       = strobe[16];
    assign ac       = strobe[17];
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: emulates the key matrix from a pressed-key set and checks
// every cycle against a scan-level run-length debounce model plus literal points.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD   = 4;
    localparam int DEB  = 3;
    localparam int SCAN = 4 * SD;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  col_in;
    logic [3:0]  row_out;
    logic [9:0]  Input;
    logic        plus, minus, mul, div, square, equal, ce, ac;
    logic [4:0]  key_code;
    logic        key_valid;
    logic [19:0] keys = '0;
    logic        chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ecount;
    bit          armed;
    int          run, none_run, last;
    logic [17:0] exp_strobe;
    logic        exp_valid;
    logic [4:0]  exp_code;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
        .sys_clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
        .Input(Input), .plus(plus), .minus(minus), .mul(mul), .div(div),
        .square(square), .equal(equal), .ce(ce), .ac(ac),
        .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its column low while its row is driven low.
    always_comb begin
        logic [4:0] m;
        m = '1;
        for (int r = 0; r < 4; r++)
            if (!row_out[r]) m = m & ~keys[r*5 +: 5];
        col_in = m;
    end

    function automatic int cand_of(logic [19:0] k);
        if ($countones(k) != 1 || k[19:18] != 2'b00) return -1;
        return $clog2(k);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ecount);
        end
    endtask

    // A press is accepted when an armed keypad sees DEB identical single-key scans;
    // it re-arms only after DEB consecutive empty scans.
    always @(posedge clk or negedge rst_n) begin : model
        int c, r, nr;
        bit a, v;
        logic [17:0] s;
        if (!rst_n) begin
            ecount <= 0; armed <= 1'b1; run <= 0; none_run <= 0; last <= -1;
            exp_strobe <= '0; exp_valid <= 1'b0; exp_code <= '0;
        end else begin
            s = '0; v = 1'b0; a = armed; r = run; nr = none_run; c = -1;
            if (ecount % SCAN == SCAN - 1) begin
                c = cand_of(keys);
                if (c < 0) begin
                    r = 0;
                    nr = nr + 1;
                    if (nr >= DEB) a = 1'b1;
                end else begin
                    nr = 0;
                    r = (c == last) ? r + 1 : 1;
                    if (a && r == DEB) begin
                        a = 1'b0;
                        v = 1'b1;
                        s = 18'(1) << c;
                    end
                end
                last <= c;
            end
            armed <= a; run <= r; none_run <= nr;
            exp_strobe <= s; exp_valid <= v;
            if (v) exp_code <= 5'(c);
            ecount <= ecount + 1;
        end
    end

    always @(negedge clk) begin
        logic [17:0] dv;
        logic [3:0]  er;
        dv = {ac, ce, equal, square, div, mul, minus, plus, Input};
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_row", row_out, 4'b1110);
                chk("rst_strobe", dv, 18'd0);
                chk("rst_valid", key_valid, 1'b0);
                chk("rst_code", key_code, 5'd0);
            end else begin
                er = ~(4'b0001 << ((ecount / SD) % 4));
                chk("row_out", row_out, er);
                chk("strobes", dv, exp_strobe);
                chk("key_valid", key_valid, exp_valid);
                chk("key_code", key_code, exp_code);
            end
        end
    end

    task automatic at_cyc(int c);
        for (int i = 0; i < 4000 && ecount != c; i++) @(negedge clk);
        if (ecount != c) begin
            n_cmp++;
            n_bad++;
            $display("FAIL at_cyc: got cycle %0d expected %0d", ecount, c);
        end
    endtask

    task automatic start(logic [19:0] k);
        @(negedge clk);
        #1 rst_n = 1'b0;
        keys = k;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_scan(int s, logic [19:0] k);
        at_cyc(SCAN * s);
        #1 keys = k;
    endtask

    initial begin
        // 1: key 7 held from reset
        start(20'd1 << 7);
        at_cyc(47); chk("t1_before", key_valid, 1'b0);
        at_cyc(48); chk("t1_digit", Input, 10'b0010000000);
        chk("t1_valid", key_valid, 1'b1);
        chk("t1_code", key_code, 5'd7);
        at_cyc(49); chk("t1_after", key_valid, 1'b0);
        chk("t1_hold_code", key_code, 5'd7);
        at_cyc(8 * SCAN);
        // 2: ac, release, then plus
        start(20'd1 << 17);
        at_cyc(48); chk("t2_ac", ac, 1'b1);
        set_scan(4, '0);
        set_scan(7, 20'd1 << 10);
        at_cyc(159); chk("t2_no_early", plus, 1'b0);
        at_cyc(160); chk("t2_plus", plus, 1'b1);
        chk("t2_code", key_code, 5'd10);
        at_cyc(12 * SCAN);
        // 3: bouncing key 3
        start(20'd1 << 3);
        set_scan(2, '0);
        set_scan(3, 20'd1 << 3);
        at_cyc(48); chk("t3_no_48", key_valid, 1'b0);
        at_cyc(96); chk("t3_digit", Input, 10'b0000001000);
        at_cyc(8 * SCAN);
        // 4: ghosted 2+8, then 2 alone
        start((20'd1 << 2) | (20'd1 << 8));
        set_scan(10, 20'd1 << 2);
        at_cyc(207); chk("t4_no_early", key_valid, 1'b0);
        at_cyc(208); chk("t4_digit", Input, 10'b0000000100);
        at_cyc(15 * SCAN);
        // 5: unused key 18, row sequence
        start(20'd1 << 18);
        at_cyc(3);  chk("t5_row0", row_out, 4'b1110);
        at_cyc(4);  chk("t5_row1", row_out, 4'b1101);
        at_cyc(8);  chk("t5_row2", row_out, 4'b1011);
        at_cyc(12); chk("t5_row3", row_out, 4'b0111);
        at_cyc(16); chk("t5_wrap", row_out, 4'b1110);
        at_cyc(10 * SCAN);
        chk("t5_code", key_code, 5'd0);
        // 6: reset during debounce of key 5
        start(20'd1 << 5);
        at_cyc(40);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_row", row_out, 4'b1110);
        chk("t6_rst_valid", key_valid, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        at_cyc(47); chk("t6_no_early", key_valid, 1'b0);
        at_cyc(48); chk("t6_digit", Input, 10'b0000100000);
        chk("t6_code", key_code, 5'd5);
        at_cyc(6 * SCAN);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
